dmem_arbiter: RTL and testbench

Two-requester arbiter that shares the single-port byte-addressable data memory between the CPU load/store stage and a DMA/debug loader port. It sits between the requesters and the data memory's mem_read/mem_write/address/write_data/funct3/read_data port. It issues at most one access per cycle and returns registered load data with a one-cycle response pulse. It rejects misaligned or unsupported accesses with an error pulse instead of issuing them.

---
 rtl/dmem_arbiter_if.sv | 50 +++++
 rtl/dmem_arbiter.sv | 109 ++++++++++
 tb/tb_dmem_arbiter.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - request, response and memory-side signals of the data-memory arbiter
interface dmem_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [2:0]        cpu_funct3;
    logic              cpu_stall;
    logic              cpu_rvalid;
    logic              cpu_err;
    logic [DATA_W-1:0] cpu_rdata;

    logic              dma_req;
    logic              dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata;
    logic [2:0]        dma_funct3;
    logic              dma_gnt;
    logic              dma_rvalid;
    logic              dma_err;
    logic [DATA_W-1:0] dma_rdata;

    logic              m_read;
    logic              m_write;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [2:0]        m_funct3;
    logic [DATA_W-1:0] m_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_funct3,
        output cpu_stall, cpu_rvalid, cpu_err, cpu_rdata,
        input  dma_req, dma_we, dma_addr, dma_wdata, dma_funct3,
        output dma_gnt, dma_rvalid, dma_err, dma_rdata,
        output m_read, m_write, m_addr, m_wdata, m_funct3,
        input  m_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_funct3,
        input  cpu_stall, cpu_rvalid, cpu_err, cpu_rdata,
        output dma_req, dma_we, dma_addr, dma_wdata, dma_funct3,
        input  dma_gnt, dma_rvalid, dma_err, dma_rdata,
        input  m_read, m_write, m_addr, m_wdata, m_funct3,
        output m_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - CPU/DMA arbiter for the single-port data memory with starvation guard and access checks
module dmem_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          reset,
    dmem_arbiter_if.slave bus
);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0]        starve_cnt;
    logic              cpu_gnt;
    logic              dma_gnt;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [2:0]        sel_funct3;
    logic              legal;
    logic              cpu_load;
    logic              dma_load;

    logic              cpu_rvalid_q;
    logic              cpu_err_q;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic              dma_rvalid_q;
    logic              dma_err_q;
    logic [DATA_W-1:0] dma_rdata_q;

    // DMA wins when alone or once the CPU has used up its streak allowance
    always_comb begin
        dma_gnt = ~reset & bus.dma_req & (~bus.cpu_req | (starve_cnt == STARVE_LIM));
        cpu_gnt = ~reset & bus.cpu_req & ~dma_gnt;
    end

    always_comb begin
        sel_we     = 1'b0;
        sel_addr   = '0;
        sel_wdata  = '0;
        sel_funct3 = 3'b000;
        if (dma_gnt) begin
            sel_we     = bus.dma_we;
            sel_addr   = bus.dma_addr;
            sel_wdata  = bus.dma_wdata;
            sel_funct3 = bus.dma_funct3;
        end else if (cpu_gnt) begin
            sel_we     = bus.cpu_we;
            sel_addr   = bus.cpu_addr;
            sel_wdata  = bus.cpu_wdata;
            sel_funct3 = bus.cpu_funct3;
        end
    end

    // Unsigned byte/halfword forms exist only for loads
    always_comb begin
        legal = 1'b0;
        case (sel_funct3)
            3'b000:  legal = 1'b1;
            3'b001:  legal = ~sel_addr[0];
            3'b010:  legal = (sel_addr[1:0] == 2'b00);
            3'b100:  legal = ~sel_we;
            3'b101:  legal = ~sel_we & ~sel_addr[0];
            default: legal = 1'b0;
        endcase
    end

    assign cpu_load = cpu_gnt & legal & ~sel_we;
    assign dma_load = dma_gnt & legal & ~sel_we;

    assign bus.m_read    = (cpu_gnt | dma_gnt) & legal & ~sel_we;
    assign bus.m_write   = (cpu_gnt | dma_gnt) & legal & sel_we;
    assign bus.m_addr    = sel_addr;
    assign bus.m_wdata   = sel_wdata;
    assign bus.m_funct3  = sel_funct3;
    assign bus.cpu_stall = bus.cpu_req & ~cpu_gnt;
    assign bus.dma_gnt   = dma_gnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt   <= 4'd0;
            cpu_rvalid_q <= 1'b0;
            cpu_err_q    <= 1'b0;
            cpu_rdata_q  <= '0;
            dma_rvalid_q <= 1'b0;
            dma_err_q    <= 1'b0;
            dma_rdata_q  <= '0;
        end else begin
            if (dma_gnt | ~bus.dma_req) begin
                starve_cnt <= 4'd0;
            end else if (cpu_gnt && starve_cnt != STARVE_LIM) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
            cpu_rvalid_q <= cpu_load;
            cpu_err_q    <= cpu_gnt & ~legal;
            dma_rvalid_q <= dma_load;
            dma_err_q    <= dma_gnt & ~legal;
            if (cpu_load) cpu_rdata_q <= bus.m_rdata;
            if (dma_load) dma_rdata_q <= bus.m_rdata;
        end
    end

    assign bus.cpu_rvalid = cpu_rvalid_q;
    assign bus.cpu_err    = cpu_err_q;
    assign bus.cpu_rdata  = cpu_rdata_q;
    assign bus.dma_rvalid = dma_rvalid_q;
    assign bus.dma_err    = dma_err_q;
    assign bus.dma_rdata  = dma_rdata_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed bench with a cycle-level reference model of the data-memory arbiter
module tb_dmem_arbiter;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int SMAX = 4;
    localparam int MSIZE = 1 << AW;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ld_val(input logic [2:0] f3, input logic [7:0] b0, b1, b2, b3);
        case (f3)
            3'b000:  return {{24{b0[7]}}, b0};
            3'b001:  return {{16{b1[7]}}, b1, b0};
            3'b100:  return {24'h0, b0};
            3'b101:  return {16'h0, b1, b0};
            default: return {b3, b2, b1, b0};
        endcase
    endfunction

    // Behavioural data memory seen by the arbiter
    logic [7:0]    mem [0:MSIZE-1];
    logic [AW-1:0] a1, a2, a3;
    assign a1 = bus.m_addr + 10'd1;
    assign a2 = bus.m_addr + 10'd2;
    assign a3 = bus.m_addr + 10'd3;
    assign bus.m_rdata = ld_val(bus.m_funct3, mem[bus.m_addr], mem[a1], mem[a2], mem[a3]);

    always @(posedge clk) begin
        if (bus.m_write) begin
            mem[bus.m_addr] <= bus.m_wdata[7:0];
            if (bus.m_funct3[1:0] != 2'b00) mem[a1] <= bus.m_wdata[15:8];
            if (bus.m_funct3[1:0] == 2'b10) begin
                mem[a2] <= bus.m_wdata[23:16];
                mem[a3] <= bus.m_wdata[31:24];
            end
        end
    end

    // Reference model: its own byte image, streak counter and expected responses
    logic [7:0]  ref_mem [0:MSIZE-1];
    int          streak = 0;
    logic        e_cpu_rvalid = 0, e_cpu_err = 0, e_dma_rvalid = 0, e_dma_err = 0;
    logic [31:0] e_cpu_rdata = 0, e_dma_rdata = 0;

    function automatic bit is_legal(input bit we, input logic [2:0] f3, input logic [AW-1:0] a);
        int sz;
        bit ok;
        ok = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        sz = 1 << f3[1:0];
        return ok && ((int'(a) % sz) == 0);
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [AW-1:0] a);
        return ld_val(f3, ref_mem[int'(a)], ref_mem[(int'(a) + 1) % MSIZE],
                      ref_mem[(int'(a) + 2) % MSIZE], ref_mem[(int'(a) + 3) % MSIZE]);
    endfunction

    always @(negedge clk) begin
        int            w;
        bit            we, ok;
        logic [AW-1:0] a;
        logic [31:0]   wd;
        logic [2:0]    f3;
        if (reset) begin
            chk("rst_cpu_rvalid", 32'(bus.cpu_rvalid), 0);
            chk("rst_dma_rvalid", 32'(bus.dma_rvalid), 0);
            chk("rst_cpu_err", 32'(bus.cpu_err), 0);
            chk("rst_dma_err", 32'(bus.dma_err), 0);
            chk("rst_cpu_rdata", bus.cpu_rdata, 0);
            chk("rst_dma_rdata", bus.dma_rdata, 0);
            chk("rst_cpu_stall", 32'(bus.cpu_stall), 32'(bus.cpu_req));
            chk("rst_dma_gnt", 32'(bus.dma_gnt), 0);
            chk("rst_m_read", 32'(bus.m_read), 0);
            chk("rst_m_write", 32'(bus.m_write), 0);
            streak = 0;
            {e_cpu_rvalid, e_cpu_err, e_dma_rvalid, e_dma_err} = '0;
            e_cpu_rdata = 0;
            e_dma_rdata = 0;
        end else begin
            chk("cpu_rvalid", 32'(bus.cpu_rvalid), 32'(e_cpu_rvalid));
            chk("cpu_err", 32'(bus.cpu_err), 32'(e_cpu_err));
            chk("cpu_rdata", bus.cpu_rdata, e_cpu_rdata);
            chk("dma_rvalid", 32'(bus.dma_rvalid), 32'(e_dma_rvalid));
            chk("dma_err", 32'(bus.dma_err), 32'(e_dma_err));
            chk("dma_rdata", bus.dma_rdata, e_dma_rdata);

            if (bus.cpu_req && bus.dma_req) w = (streak == SMAX) ? 2 : 1;
            else if (bus.cpu_req) w = 1;
            else if (bus.dma_req) w = 2;
            else w = 0;
            we = (w == 2) ? bus.dma_we : bus.cpu_we;
            a  = (w == 2) ? bus.dma_addr : bus.cpu_addr;
            wd = (w == 2) ? bus.dma_wdata : bus.cpu_wdata;
            f3 = (w == 2) ? bus.dma_funct3 : bus.cpu_funct3;
            ok = (w != 0) && is_legal(we, f3, a);

            chk("cpu_stall", 32'(bus.cpu_stall), 32'(bus.cpu_req && w != 1));
            chk("dma_gnt", 32'(bus.dma_gnt), 32'(w == 2));
            chk("m_read", 32'(bus.m_read), 32'(ok && !we));
            chk("m_write", 32'(bus.m_write), 32'(ok && we));
            if (w == 0) begin
                chk("idle_m_addr", 32'(bus.m_addr), 0);
                chk("idle_m_wdata", bus.m_wdata, 0);
                chk("idle_m_funct3", 32'(bus.m_funct3), 0);
            end else if (ok) begin
                chk("m_addr", 32'(bus.m_addr), 32'(a));
                chk("m_wdata", bus.m_wdata, wd);
                chk("m_funct3", 32'(bus.m_funct3), 32'(f3));
            end

            streak = (bus.dma_req && w == 1) ? ((streak < SMAX) ? streak + 1 : SMAX) : 0;
            e_cpu_rvalid = (w == 1) && ok && !we;
            e_dma_rvalid = (w == 2) && ok && !we;
            e_cpu_err    = (w == 1) && !ok;
            e_dma_err    = (w == 2) && !ok;
            if (e_cpu_rvalid) e_cpu_rdata = ref_load(f3, a);
            if (e_dma_rvalid) e_dma_rdata = ref_load(f3, a);
            if (ok && we) begin
                for (int k = 0; k < (1 << f3[1:0]); k++)
                    ref_mem[(int'(a) + k) % MSIZE] = wd[8*k +: 8];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.cpu_req = 0;
        bus.dma_req = 0;
    endtask

    task automatic cpu(input bit we, input logic [AW-1:0] a, input logic [31:0] d, input logic [2:0] f3);
        bus.cpu_req = 1; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d; bus.cpu_funct3 = f3;
    endtask

    task automatic dma(input bit we, input logic [AW-1:0] a, input logic [31:0] d, input logic [2:0] f3);
        bus.dma_req = 1; bus.dma_we = we; bus.dma_addr = a; bus.dma_wdata = d; bus.dma_funct3 = f3;
    endtask

    initial begin
        for (int i = 0; i < MSIZE; i++) begin
            mem[i] = 8'h00;
            ref_mem[i] = 8'h00;
        end
        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0; bus.cpu_funct3 = 0;
        bus.dma_req = 0; bus.dma_we = 0; bus.dma_addr = 0; bus.dma_wdata = 0; bus.dma_funct3 = 0;
        reset = 1;
        tick();
        tick();
        chk("lit_reset_cpu_rdata", bus.cpu_rdata, 32'h0);
        reset = 0;
        tick();

        // Store then load the same word
        cpu(1, 10'h010, 32'hDEADBEEF, 3'b010);
        #2 chk("lit_sw_stall", 32'(bus.cpu_stall), 0);
        chk("lit_sw_write", 32'(bus.m_write), 1);
        tick();
        cpu(0, 10'h010, 32'h0, 3'b010);
        #2 chk("lit_lw_stall", 32'(bus.cpu_stall), 0);
        tick();
        idle();
        chk("lit_lw_rvalid", 32'(bus.cpu_rvalid), 1);
        chk("lit_lw_rdata", bus.cpu_rdata, 32'hDEADBEEF);
        tick();
        chk("lit_lw_rvalid_drop", 32'(bus.cpu_rvalid), 0);

        // Contention: four CPU grants then one forced DMA grant, repeating
        cpu(0, 10'h010, 32'h0, 3'b010);
        dma(0, 10'h010, 32'h0, 3'b010);
        for (int i = 0; i < 10; i++) begin
            #2 chk("lit_pattern_stall", 32'(bus.cpu_stall), 32'((i % 5) == 4));
            chk("lit_pattern_dma_gnt", 32'(bus.dma_gnt), 32'((i % 5) == 4));
            tick();
        end
        idle();
        tick();

        // Byte store from DMA, signed and unsigned byte loads from CPU
        dma(1, 10'h003, 32'h00000080, 3'b000);
        tick();
        idle();
        cpu(0, 10'h003, 32'h0, 3'b000);
        tick();
        cpu(0, 10'h003, 32'h0, 3'b100);
        tick();
        idle();
        tick();
        cpu(0, 10'h003, 32'h0, 3'b000);
        tick();
        idle();
        chk("lit_lb_sext", bus.cpu_rdata, 32'hFFFFFF80);
        cpu(0, 10'h003, 32'h0, 3'b100);
        tick();
        idle();
        chk("lit_lbu_zext", bus.cpu_rdata, 32'h00000080);
        tick();

        // Rejected accesses
        cpu(0, 10'h006, 32'h0, 3'b010);
        #2 chk("lit_misaligned_m_read", 32'(bus.m_read), 0);
        tick();
        idle();
        chk("lit_misaligned_err", 32'(bus.cpu_err), 1);
        chk("lit_misaligned_rvalid", 32'(bus.cpu_rvalid), 0);
        cpu(1, 10'h010, 32'h12345678, 3'b011);
        #2 chk("lit_bad_store_m_write", 32'(bus.m_write), 0);
        tick();
        idle();
        chk("lit_bad_store_err", 32'(bus.cpu_err), 1);
        cpu(0, 10'h010, 32'h0, 3'b010);
        tick();
        idle();
        chk("lit_readback_unchanged", bus.cpu_rdata, 32'hDEADBEEF);
        dma(0, 10'h001, 32'h0, 3'b001);
        tick();
        idle();
        chk("lit_dma_misaligned_err", 32'(bus.dma_err), 1);
        tick();

        // Simultaneous loads: responses are split by owner
        dma(1, 10'h020, 32'hCAFEF00D, 3'b010);
        tick();
        cpu(0, 10'h010, 32'h0, 3'b010);
        dma(0, 10'h020, 32'h0, 3'b010);
        tick();
        bus.cpu_req = 0;
        chk("lit_split_cpu_rvalid", 32'(bus.cpu_rvalid), 1);
        chk("lit_split_cpu_rdata", bus.cpu_rdata, 32'hDEADBEEF);
        chk("lit_split_dma_hold", bus.dma_rdata, 32'hDEADBEEF);
        chk("lit_split_dma_rvalid0", 32'(bus.dma_rvalid), 0);
        tick();
        idle();
        chk("lit_split_dma_rvalid", 32'(bus.dma_rvalid), 1);
        chk("lit_split_dma_rdata", bus.dma_rdata, 32'hCAFEF00D);
        chk("lit_split_cpu_hold", bus.cpu_rdata, 32'hDEADBEEF);
        chk("lit_split_cpu_rvalid0", 32'(bus.cpu_rvalid), 0);
        tick();

        // Reset in the cycle after a granted load discards the response
        cpu(0, 10'h020, 32'h0, 3'b010);
        tick();
        idle();
        reset = 1;
        #1 chk("lit_rst_mid_rvalid", 32'(bus.cpu_rvalid), 0);
        chk("lit_rst_mid_rdata", bus.cpu_rdata, 32'h0);
        tick();
        reset = 0;
        tick();
        chk("lit_post_rst_rvalid", 32'(bus.cpu_rvalid), 0);
        chk("lit_post_rst_err", 32'(bus.cpu_err), 0);
        chk("lit_post_rst_cpu_rdata", bus.cpu_rdata, 32'h0);
        chk("lit_post_rst_dma_rdata", bus.dma_rdata, 32'h0);
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
